exec_trace_recorder: RTL and testbench

Synthesizable on-chip execution trace recorder for the synapse316 target. It samples the executing instruction's code address and exr on every exec-enabled cycle into a circular buffer. Recording stops a programmable number of samples after a selectable trigger. The supervisor reads captured entries back by index, which gives in-silicon tracing of the (addr, exr) stream without a simulator.

---
 rtl/exec_trace_recorder_if.sv | 34 +++
 rtl/exec_trace_recorder.sv | 93 +++++++++
 tb/tb_exec_trace_recorder.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/exec_trace_recorder_if.sv
// exec_trace_recorder_if: sample, control and readback signals of the trace recorder
// Ports (signals): enable_exec/code_addr/exr carry the sampled stream; arm/abort/trig_* control
// capture; rd_idx selects an entry and rd_addr/rd_exr/state/count/trig_pos/invalid_cnt report back.
// master = supervisor/target side, slave = recorder side.
interface exec_trace_recorder_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16,
  parameter int DEPTH   = 64
);
  localparam int AW = $clog2(DEPTH);
  logic               enable_exec;
  logic [ADDR_W-1:0]  code_addr;
  logic [INSTR_W-1:0] exr;
  logic               arm;
  logic               abort;
  logic [1:0]         trig_mode;
  logic [ADDR_W-1:0]  trig_addr;
  logic               trig_in;
  logic [AW-1:0]      rd_idx;
  logic [ADDR_W-1:0]  rd_addr;
  logic [INSTR_W-1:0] rd_exr;
  logic [1:0]         state;
  logic [AW:0]        count;
  logic [AW-1:0]      trig_pos;
  logic [7:0]         invalid_cnt;
  modport master (
    output enable_exec, code_addr, exr, arm, abort, trig_mode, trig_addr, trig_in, rd_idx,
    input  rd_addr, rd_exr, state, count, trig_pos, invalid_cnt
  );
  modport slave (
    input  enable_exec, code_addr, exr, arm, abort, trig_mode, trig_addr, trig_in, rd_idx,
    output rd_addr, rd_exr, state, count, trig_pos, invalid_cnt
  );
endinterface

// File: rtl/exec_trace_recorder.sv
// exec_trace_recorder: circular (addr, exr) trace buffer with selectable trigger and post-trigger stop
// Ports: sysclk, sysreset (sync, active-high); bus (exec_trace_recorder_if.slave) carries the
// sample stream, arm/abort/trigger controls, rd_idx readback select and the status outputs.
module exec_trace_recorder #(
  parameter int ADDR_W    = 16,
  parameter int INSTR_W   = 16,
  parameter int DEPTH     = 64,
  parameter int POST_TRIG = 16
) (
  input logic                 sysclk,
  input logic                 sysreset,
  exec_trace_recorder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [1:0] S_IDLE = 2'd0, S_ARMED = 2'd1, S_POST = 2'd2, S_DONE = 2'd3;
  logic [1:0]                 r_state, w_next;
  logic [AW-1:0]              r_wr_ptr, r_trig_pos, r_post, w_phys;
  logic [AW:0]                r_count;
  logic [7:0]                 r_invalid_cnt;
  logic [ADDR_W-1:0]          r_rd_addr;
  logic [INSTR_W-1:0]         r_rd_exr;
  logic [ADDR_W+INSTR_W-1:0]  r_mem [DEPTH];
  logic                       w_recording, w_sample, w_invalid, w_match, w_trig, w_post_end;

  always_ff @(posedge sysclk)
    if (sysreset) r_state <= S_IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    if (bus.arm) w_next = S_ARMED;
    else if (bus.abort && w_recording) w_next = S_IDLE;
    else if (w_trig) w_next = POST_TRIG == 0 ? S_DONE : S_POST;
    else if (w_post_end) w_next = S_DONE;
  end

  // arm and abort cycles are control cycles and never store a sample
  always_comb begin
    w_recording = r_state == S_ARMED || r_state == S_POST;
    w_sample    = bus.enable_exec && w_recording && !bus.arm && !bus.abort && !sysreset;
    w_invalid   = bus.exr == '1;
    w_match     = bus.trig_mode == 2'd0 ? 1'b1 :
                  bus.trig_mode == 2'd1 ? bus.code_addr == bus.trig_addr :
                  bus.trig_mode == 2'd2 ? w_invalid : bus.trig_in;
    w_trig      = w_sample && r_state == S_ARMED && w_match;
    w_post_end  = w_sample && r_state == S_POST && r_post == AW'(1);
    // once wrapped, the oldest entry sits at wr_ptr
    w_phys      = (r_count == FULL ? r_wr_ptr : '0) + bus.rd_idx;
    bus.state       = r_state;
    bus.count       = r_count;
    bus.trig_pos    = r_trig_pos;
    bus.invalid_cnt = r_invalid_cnt;
    bus.rd_addr     = r_rd_addr;
    bus.rd_exr      = r_rd_exr;
  end

  always_ff @(posedge sysclk)
    if (w_sample) r_mem[r_wr_ptr] <= {bus.code_addr, bus.exr};

  always_ff @(posedge sysclk)
    if (sysreset) begin
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_trig_pos    <= '0;
      r_invalid_cnt <= '0;
      r_post        <= '0;
      r_rd_addr     <= '0;
      r_rd_exr      <= '0;
    end else begin
      r_rd_addr <= r_mem[w_phys][ADDR_W+INSTR_W-1:INSTR_W];
      r_rd_exr  <= r_mem[w_phys][INSTR_W-1:0];
      if (bus.arm) begin
        r_wr_ptr      <= '0;
        r_count       <= '0;
        r_trig_pos    <= '0;
        r_invalid_cnt <= '0;
        r_post        <= '0;
      end else if (w_sample) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (r_count != FULL) r_count <= r_count + 1'b1;
        if (w_invalid && r_invalid_cnt != 8'hFF) r_invalid_cnt <= r_invalid_cnt + 8'd1;
        if (w_trig) begin
          r_trig_pos <= r_count == FULL ? AW'(DEPTH-1) : r_count[AW-1:0];
          r_post     <= AW'(POST_TRIG);
        end else if (r_state == S_POST) begin
          r_post <= r_post - 1'b1;
          // a full buffer drops its oldest entry, shifting the trigger one slot toward index 0
          if (r_count == FULL) r_trig_pos <= r_trig_pos - 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_exec_trace_recorder.sv
// tb_exec_trace_recorder: directed plan plus random streams against a sample-history reference model
module tb_exec_trace_recorder;
  localparam int DEPTH = 64;
  localparam int HMAX = 1024;
  logic sysclk, sysreset;
  logic en, arm, abort, tin;
  logic [15:0] addr, exr, taddr;
  logic [1:0] mode;
  logic [5:0] rd_idx;
  int n_chk = 0, n_pass = 0;
  int pt [2] = '{16, 4};
  int m_st [2], m_len [2], m_inv [2], m_tabs [2], m_rem [2];
  bit m_trig [2], m_rdok [2];
  logic [31:0] m_rd [2];
  logic [31:0] hist [2][HMAX];

  exec_trace_recorder_if #(.ADDR_W(16), .INSTR_W(16), .DEPTH(DEPTH)) if0 ();
  exec_trace_recorder_if #(.ADDR_W(16), .INSTR_W(16), .DEPTH(DEPTH)) if1 ();
  exec_trace_recorder #(.ADDR_W(16), .INSTR_W(16), .DEPTH(DEPTH), .POST_TRIG(16))
    dut0 (.sysclk(sysclk), .sysreset(sysreset), .bus(if0));
  exec_trace_recorder #(.ADDR_W(16), .INSTR_W(16), .DEPTH(DEPTH), .POST_TRIG(4))
    dut1 (.sysclk(sysclk), .sysreset(sysreset), .bus(if1));

  assign if0.enable_exec = en;    assign if1.enable_exec = en;
  assign if0.code_addr = addr;    assign if1.code_addr = addr;
  assign if0.exr = exr;           assign if1.exr = exr;
  assign if0.arm = arm;           assign if1.arm = arm;
  assign if0.abort = abort;       assign if1.abort = abort;
  assign if0.trig_mode = mode;    assign if1.trig_mode = mode;
  assign if0.trig_addr = taddr;   assign if1.trig_addr = taddr;
  assign if0.trig_in = tin;       assign if1.trig_in = tin;
  assign if0.rd_idx = rd_idx;     assign if1.rd_idx = rd_idx;

  initial sysclk = 0;
  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic int m_cnt(int k);
    return m_len[k] < DEPTH ? m_len[k] : DEPTH;
  endfunction

  // reference: the buffer is simply the last min(len,DEPTH) samples of the history since arm
  function automatic void model_edge(int k);
    int c;
    bit hit;
    c = m_cnt(k);
    m_rdok[k] = (m_st[k] == 0 || m_st[k] == 3) && int'(rd_idx) < c;
    if (m_rdok[k]) m_rd[k] = hist[k][m_len[k] - c + int'(rd_idx)];
    if (sysreset) begin
      m_st[k] = 0; m_len[k] = 0; m_inv[k] = 0; m_trig[k] = 0; m_rd[k] = 0; m_rdok[k] = 1;
    end else if (arm) begin
      m_st[k] = 1; m_len[k] = 0; m_inv[k] = 0; m_trig[k] = 0;
    end else if (abort && (m_st[k] == 1 || m_st[k] == 2)) begin
      m_st[k] = 0;
    end else if (en && (m_st[k] == 1 || m_st[k] == 2)) begin
      hist[k][m_len[k]] = {addr, exr};
      m_len[k]++;
      if (exr == 16'hFFFF && m_inv[k] < 255) m_inv[k]++;
      hit = mode == 0 || (mode == 1 && addr == taddr) || (mode == 2 && exr == 16'hFFFF) || (mode == 3 && tin);
      if (m_st[k] == 1 && hit) begin
        m_trig[k] = 1;
        m_tabs[k] = m_len[k] - 1;
        m_rem[k] = pt[k];
        m_st[k] = pt[k] == 0 ? 3 : 2;
      end else if (m_st[k] == 2) begin
        m_rem[k]--;
        if (m_rem[k] == 0) m_st[k] = 3;
      end
    end
  endfunction

  task automatic cmp(input int k, input logic [1:0] st, input logic [6:0] cnt, input logic [5:0] tp,
                     input logic [7:0] inv, input logic [15:0] ra, input logic [15:0] re);
    int c;
    c = m_cnt(k);
    chk($sformatf("state%0d", k), st, m_st[k]);
    chk($sformatf("count%0d", k), cnt, c);
    chk($sformatf("trig_pos%0d", k), tp, m_trig[k] ? m_tabs[k] - (m_len[k] - c) : 0);
    chk($sformatf("invalid%0d", k), inv, m_inv[k]);
    if (m_rdok[k]) begin
      chk($sformatf("rd_addr%0d", k), ra, m_rd[k][31:16]);
      chk($sformatf("rd_exr%0d", k), re, m_rd[k][15:0]);
    end
  endtask

  task automatic step();
    @(posedge sysclk);
    model_edge(0);
    model_edge(1);
    #1;
    cmp(0, if0.state, if0.count, if0.trig_pos, if0.invalid_cnt, if0.rd_addr, if0.rd_exr);
    cmp(1, if1.state, if1.count, if1.trig_pos, if1.invalid_cnt, if1.rd_addr, if1.rd_exr);
  endtask

  task automatic do_arm(input logic [1:0] md, input logic [15:0] ta);
    mode = md; taddr = ta; arm = 1; en = 0;
    step();
    arm = 0;
  endtask

  task automatic sample(input logic [15:0] a, input logic [15:0] x, input logic t);
    en = 1; addr = a; exr = x; tin = t;
    step();
    en = 0; tin = 0;
  endtask

  initial begin
    en = 0; arm = 0; abort = 0; tin = 0; addr = 0; exr = 0; taddr = 0; mode = 0; rd_idx = 0;
    sysreset = 1;
    step(); step();
    sysreset = 0;
    chk("rst_state", if0.state, 2'd0);
    chk("rst_rd_addr", if0.rd_addr, 16'h0);
    // immediate trigger, stop after 17 samples
    do_arm(2'd0, 16'h0);
    for (int i = 0; i < 20; i++) begin
      sample(16'h0100 + 16'(i), 16'h1000 + 16'(i), 1'b0);
      if (i == 16) begin
        chk("t1_state", if0.state, 2'd3);
        chk("t1_count", if0.count, 7'd17);
        chk("t1_trig_pos", if0.trig_pos, 6'd0);
      end
    end
    chk("t1_count_hold", if0.count, 7'd17);
    rd_idx = 0;
    step();
    chk("t1_rd_addr", if0.rd_addr, 16'h0100);
    chk("t1_rd_exr", if0.rd_exr, 16'h1000);
    // address trigger with wrap
    do_arm(2'd1, 16'h0050);
    for (int a = 0; a < 256; a++) sample(16'(a), 16'($urandom_range(0, 16'hFFFE)), 1'b0);
    chk("t2_state", if0.state, 2'd3);
    chk("t2_count", if0.count, 7'd64);
    chk("t2_trig_pos", if0.trig_pos, 6'd47);
    rd_idx = 47; step(); chk("t2_rd47", if0.rd_addr, 16'h0050);
    rd_idx = 0;  step(); chk("t2_rd0", if0.rd_addr, 16'h0021);
    rd_idx = 63; step(); chk("t2_rd63", if0.rd_addr, 16'h0060);
    // invalid-instruction trigger on the POST_TRIG=4 instance
    do_arm(2'd2, 16'h0);
    for (int i = 1; i <= 20; i++) sample(16'(i), (i == 10 || i == 12) ? 16'hFFFF : 16'h2000 + 16'(i), 1'b0);
    chk("t3_state", if1.state, 2'd3);
    chk("t3_trig_pos", if1.trig_pos, 6'd9);
    chk("t3_count", if1.count, 7'd14);
    chk("t3_invalid", if1.invalid_cnt, 8'd2);
    // external trigger ignored on a non-exec cycle
    do_arm(2'd3, 16'h0);
    tin = 1; step(); tin = 0;
    for (int i = 0; i < 3; i++) sample(16'h0300 + 16'(i), 16'h3000, 1'b0);
    chk("t4_armed", if0.state, 2'd1);
    sample(16'h0303, 16'h3003, 1'b1);
    chk("t4_post", if0.state, 2'd2);
    chk("t4_trig_pos", if0.trig_pos, 6'd3);
    // arm beats abort, and its exec cycle is not stored
    arm = 1; abort = 1; en = 1; addr = 16'h0777; exr = 16'h7777; mode = 2'd0;
    step();
    arm = 0; abort = 0; en = 0;
    chk("t5_state", if0.state, 2'd1);
    chk("t5_count", if0.count, 7'd0);
    for (int i = 0; i < 5; i++) sample(16'h0500 + 16'(i), 16'h5000 + 16'(i), 1'b0);
    chk("t5_post", if0.state, 2'd2);
    abort = 1; step(); abort = 0;
    chk("t5_abort_state", if0.state, 2'd0);
    chk("t5_abort_count", if0.count, 7'd5);
    rd_idx = 0; step();
    chk("t5_rd0", if0.rd_addr, 16'h0500);
    // reset in the middle of POST
    do_arm(2'd1, 16'h0914);
    for (int i = 0; i < 30; i++) sample(16'h0900 + 16'(i), (i % 7 == 0) ? 16'hFFFF : 16'(i), 1'b0);
    chk("t6_state", if0.state, 2'd2);
    chk("t6_count", if0.count, 7'd30);
    rd_idx = 3; step();
    sysreset = 1; step(); sysreset = 0;
    chk("t6_rst_state", if0.state, 2'd0);
    chk("t6_rst_count", if0.count, 7'd0);
    chk("t6_rst_invalid", if0.invalid_cnt, 8'd0);
    chk("t6_rst_rd_addr", if0.rd_addr, 16'h0);
    // random streams
    for (int t = 0; t < 30; t++) begin
      do_arm(2'($urandom_range(0, 3)), 16'($urandom_range(0, 15)));
      for (int c = 0; c < 150; c++) begin
        abort = $urandom_range(0, 99) == 0;
        arm = !abort && $urandom_range(0, 149) == 0;
        en = !abort && $urandom_range(0, 3) != 0;
        addr = 16'($urandom_range(0, 15));
        exr = $urandom_range(0, 7) == 0 ? 16'hFFFF : 16'($urandom_range(0, 16'hFFFE));
        tin = $urandom_range(0, 5) == 0;
        rd_idx = 6'($urandom_range(0, 63));
        step();
      end
      en = 0; arm = 0; abort = 0; tin = 0;
      for (int r = 0; r < 8; r++) begin
        rd_idx = 6'($urandom_range(0, 63));
        step();
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
